uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver, the receive end of the link driven by `uart_transmitter`. It shares the same frame format and `baud_select` encoding: 1 start bit, 8 data bits LSB first, 1 even-parity bit, 1 stop bit. It oversamples `RxD` at 16x the selected baud rate, with the divisors derived from the 100 MHz system clock. Each completed frame produces a one-cycle result strobe with data and error flags.

## Interface
- `CLK_HZ`, default 100000000: system clock frequency. The divisor list below is fixed for this value.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `RxD` in 1: serial line input. It is asynchronous and idles high.
- `baud_select` in 3: rate code. 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
- `Rx_EN` in 1: receiver enable, level-sensitive.
- `Rx_DATA` out 8: last received byte.
- `Rx_VALID` out 1: one-cycle pulse when a frame has no parity or stop error.
- `Rx_PERROR` out 1: one-cycle pulse when parity mismatches.
- `Rx_FERROR` out 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- `RxD` passes through a 2-flop synchronizer. All decisions use the synchronized copy `rx_s`.
- Sample-tick divisors are round(CLK_HZ/(16*baud)): 20833, 5208, 1302, 651, 326, 163, 109, 54. `tick` is a one-clk pulse when the divisor counter reaches divisor-1. The counter then wraps to 0.
- `baud_select` is latched when the start edge is detected. Changes mid-frame do not affect the current frame.
- A 4-bit `os_cnt` counts ticks within a bit. A 3-bit `bit_cnt` indexes the data bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on `Rx_EN`=1 and a `rx_s` falling edge (previous 1, current 0), go to START. The divisor counter and `os_cnt` clear to 0.
  - START: on the tick where `os_cnt`=7 (mid-bit), if `rx_s`=0 clear `os_cnt` and go to DATA. If `rx_s`=1 it is a false start; return to IDLE with no strobes.
  - DATA: on the tick where `os_cnt`=15, shift `rx_s` into the shift register at bit `bit_cnt` (LSB first) and increment `bit_cnt`. After bit 7, go to PARITY.
  - PARITY: on the tick where `os_cnt`=15, capture the parity bit and go to STOP.
  - STOP: on the tick where `os_cnt`=15, evaluate the frame and return to IDLE in the same cycle, so back-to-back frames are accepted.
- Evaluation registers its outputs one clk later:
  - `Rx_DATA` is updated with the shift register on every completed frame, including errored frames.
  - `Rx_PERROR` = (^data) ^ parity_bit. Even parity means the XOR of 9 bits is 0.
  - `Rx_FERROR` = ~stop_sample.
  - `Rx_VALID` = ~Rx_PERROR & ~Rx_FERROR.
- `Rx_EN`=0 forces IDLE from any state and aborts a partial frame with no strobes. `Rx_DATA` keeps its value.
- Reset values: `Rx_DATA`=8'h00, `Rx_VALID`=0, `Rx_PERROR`=0, `Rx_FERROR`=0. The FSM is in IDLE, all counters are 0, and both synchronizer flops are 1.
- Reset asserted mid-frame aborts the frame immediately. No strobe appears after release.
- An `RxD` held low continuously (line break) gives a frame of 0x00 with `Rx_FERROR`=1. No new frame starts until a rising then falling edge is seen.

## Timing
- Synchronizer latency is 2 clk from the `RxD` edge to `rx_s`.
- Bit period is 16 ticks. At 115200 it is 16*54 = 864 clk = 8.64 us.
- Mid-start sample is 8 ticks after the edge. Each following sample is 16 ticks after the previous one, so all samples fall at bit centres.
- Strobe latency is 2 (sync) + 1 (edge) + (8+16*10)*divisor + 1 clk after the `RxD` falling edge. At 115200 this is about 9076 clk, which is mid-stop-bit plus the registered output.
- All strobes are exactly one clk wide. At most one of `Rx_VALID` or the error pair asserts per frame. `Rx_PERROR` and `Rx_FERROR` may assert together.
- `Rx_DATA` is stable from its strobe cycle until the next frame completes.

## Test plan
- Reset, `Rx_EN`=1, `baud_select`=111, send frames 0xAA, 0x55, 0xCC (parity 0) and 0x89 (parity 1) at 8.64 us/bit with 30 us gaps. Each frame gives `Rx_VALID` pulse with `Rx_DATA` equal to the byte and no error pulses.
- Send 0xAA with parity bit 1 at 115200 -> `Rx_PERROR` pulse, `Rx_VALID`=0, `Rx_DATA`=0xAA. Send 0x55 with stop bit 0 -> `Rx_FERROR` pulse.
- Drive a 200 ns low glitch on an idle `RxD` -> false start. No strobe, and FSM is back in IDLE about 4.3 us later. A valid 0x55 sent afterwards is received correctly.
- Send 0x89 then 0xCC back-to-back with no idle gap, with `baud_select`=011 (9600, divisor 651) -> two `Rx_VALID` pulses with data 0x89 then 0xCC.
- Drop `Rx_EN` during data bit 3 of 0xAA, then re-raise it before the next frame -> no strobe for the aborted frame, `Rx_DATA` holds its old value, and the next 0x55 is received.
- Assert `reset` mid-frame -> all outputs 0 immediately, and no strobe after reset is released.

Source files
------------

// File: rtl/uart_receiver.sv
`timescale 1ns / 1ps
// uart_receiver
//
// Serial-to-parallel UART receiver for 8E1 frames: 1 start bit, 8 data bits LSB first,
// 1 even-parity bit and 1 stop bit. RxD is oversampled at 16x the selected baud rate.
// Each completed frame produces a one-cycle strobe on either Rx_VALID or the error pair,
// one clk after the mid-stop-bit sample.
//
// Parameters:
//   CLK_HZ       system clock frequency; sample-tick divisors are derived from it
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   RxD          serial line input (asynchronous, idles high)
//   baud_select  rate code: 0=300 1=1200 2=4800 3=9600 4=19200 5=38400 6=57600 7=115200
//   Rx_EN        receiver enable; low forces idle and aborts any partial frame
//   Rx_DATA      last received byte, updated on every completed frame
//   Rx_VALID     one-cycle pulse for a frame without parity or stop error
//   Rx_PERROR    one-cycle pulse when the even-parity check fails
//   Rx_FERROR    one-cycle pulse when the stop bit is sampled low

module uart_receiver #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  // round(CLK_HZ / (16 * baud)) with integer arithmetic
  function automatic logic [15:0] tick_div(input int unsigned baud);
    int unsigned d;
    d = (CLK_HZ + 8 * baud) / (16 * baud);
    return d[15:0];
  endfunction

  localparam logic [15:0] Div300    = tick_div(300);
  localparam logic [15:0] Div1200   = tick_div(1200);
  localparam logic [15:0] Div4800   = tick_div(4800);
  localparam logic [15:0] Div9600   = tick_div(9600);
  localparam logic [15:0] Div19200  = tick_div(19200);
  localparam logic [15:0] Div38400  = tick_div(38400);
  localparam logic [15:0] Div57600  = tick_div(57600);
  localparam logic [15:0] Div115200 = tick_div(115200);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e state_q, state_d;

  // Input synchronizer and edge-detect history
  logic rx_meta_q;
  logic rx_s;
  logic rx_prev_q;
  logic fall;

  // Timing and datapath state
  logic [2:0]  baud_q;
  logic [15:0] div_cnt_q;
  logic [15:0] div_max;
  logic        tick;
  logic [3:0]  os_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        parity_q;

  // FSM-decoded control strobes
  logic start_det;
  logic mid_start;
  logic sample_data;
  logic sample_par;
  logic eval;

  logic perr_calc;
  logic ferr_calc;

  //--------------------------------------------------------------------------
  // Synchronizer: both flops reset to the idle line level so that reset
  // release on an idle line never looks like a start edge.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rx_s      <= rx_meta_q;
      rx_prev_q <= rx_s;
    end
  end

  assign fall = rx_prev_q & ~rx_s;

  //--------------------------------------------------------------------------
  // Tick generator: divisor chosen by the rate latched at the start edge
  //--------------------------------------------------------------------------
  always_comb begin
    div_max = Div115200 - 16'd1;
    unique case (baud_q)
      3'd0: div_max = Div300    - 16'd1;
      3'd1: div_max = Div1200   - 16'd1;
      3'd2: div_max = Div4800   - 16'd1;
      3'd3: div_max = Div9600   - 16'd1;
      3'd4: div_max = Div19200  - 16'd1;
      3'd5: div_max = Div38400  - 16'd1;
      3'd6: div_max = Div57600  - 16'd1;
      3'd7: div_max = Div115200 - 16'd1;
    endcase
  end

  assign tick = (div_cnt_q == div_max);

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!Rx_EN) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fall) state_d = StStart;
        end
        StStart: begin
          // Mid-start sample: a high line here was only a glitch
          if (tick && os_cnt_q == 4'd7) state_d = rx_s ? StIdle : StData;
        end
        StData: begin
          if (tick && os_cnt_q == 4'd15 && bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          if (tick && os_cnt_q == 4'd15) state_d = StStop;
        end
        StStop: begin
          // Leave at mid-stop so a following start edge is never missed
          if (tick && os_cnt_q == 4'd15) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // FSM: control outputs
  //--------------------------------------------------------------------------
  always_comb begin
    start_det   = 1'b0;
    mid_start   = 1'b0;
    sample_data = 1'b0;
    sample_par  = 1'b0;
    eval        = 1'b0;
    if (Rx_EN) begin
      unique case (state_q)
        StIdle:   start_det   = fall;
        StStart:  mid_start   = tick && (os_cnt_q == 4'd7);
        StData:   sample_data = tick && (os_cnt_q == 4'd15);
        StParity: sample_par  = tick && (os_cnt_q == 4'd15);
        StStop:   eval        = tick && (os_cnt_q == 4'd15);
        default: ;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Counters, rate latch and shift register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q    <= 3'd0;
      div_cnt_q <= 16'd0;
      os_cnt_q  <= 4'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
    end else if (state_q == StIdle || !Rx_EN) begin
      // Counters sit at zero while idle so the first tick lands one full
      // divisor period after the start edge.
      div_cnt_q <= 16'd0;
      os_cnt_q  <= 4'd0;
      bit_cnt_q <= 3'd0;
      if (start_det) baud_q <= baud_select;
    end else begin
      div_cnt_q <= tick ? 16'd0 : div_cnt_q + 16'd1;
      if (tick) os_cnt_q <= mid_start ? 4'd0 : os_cnt_q + 4'd1;
      if (sample_data) begin
        shift_q[bit_cnt_q] <= rx_s;
        bit_cnt_q          <= bit_cnt_q + 3'd1;
      end
      if (sample_par) parity_q <= rx_s;
    end
  end

  //--------------------------------------------------------------------------
  // Frame evaluation, registered one clk after the stop sample
  //--------------------------------------------------------------------------
  assign perr_calc = (^shift_q) ^ parity_q;
  assign ferr_calc = ~rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
      if (eval) begin
        Rx_DATA   <= shift_q;
        Rx_VALID  <= ~perr_calc & ~ferr_calc;
        Rx_PERROR <= perr_calc;
        Rx_FERROR <= ferr_calc;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns / 1ps
module tb_uart_receiver;

  // 10 MHz system clock keeps the 9600-baud back-to-back case short.
  // Hand-computed divisors: 1e7/(16*115200)=5.43 -> 5, 1e7/(16*9600)=65.1 -> 65.
  localparam int unsigned ClkHz = 10000000;
  localparam int Div115k   = 5;
  localparam int Div9600   = 65;
  localparam int Bit115k   = 16 * Div115k;
  localparam int Bit9600   = 16 * Div9600;
  localparam int Gap       = 300;
  localparam int ExpLatency = 2 + 1 + (8 + 16 * 10) * Div115k + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  always #50 clk = ~clk;

  uart_receiver #(.CLK_HZ(ClkHz)) dut (
    .clk        (clk),
    .reset      (reset),
    .RxD        (RxD),
    .baud_select(baud_select),
    .Rx_EN      (Rx_EN),
    .Rx_DATA    (Rx_DATA),
    .Rx_VALID   (Rx_VALID),
    .Rx_PERROR  (Rx_PERROR),
    .Rx_FERROR  (Rx_FERROR)
  );

  int tests = 0;
  int fails = 0;

  // Strobe monitor
  int cyc = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0;
  int strobe_cyc = 0;
  int fall_cyc = 0;
  int wide_cnt = 0, excl_cnt = 0;
  logic pv = 1'b0, pp = 1'b0, pf = 1'b0;
  logic [7:0] data_log[$];
  int b_v, b_p, b_f;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (Rx_VALID) begin
      n_valid = n_valid + 1;
      data_log.push_back(Rx_DATA);
    end
    if (Rx_PERROR) n_perr = n_perr + 1;
    if (Rx_FERROR) n_ferr = n_ferr + 1;
    if (Rx_VALID || Rx_PERROR || Rx_FERROR) strobe_cyc = cyc;
    if ((Rx_VALID && pv) || (Rx_PERROR && pp) || (Rx_FERROR && pf)) wide_cnt = wide_cnt + 1;
    if (Rx_VALID && (Rx_PERROR || Rx_FERROR)) excl_cnt = excl_cnt + 1;
    pv = Rx_VALID;
    pp = Rx_PERROR;
    pf = Rx_FERROR;
  end

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_v;
    logic       exp_p;
    logic       exp_f;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_v = n_valid;
    b_p = n_perr;
    b_f = n_ferr;
  endtask

  task automatic frame_check(input string tag, input int ev, input int ep, input int ef,
                             input logic [7:0] ed);
    check({tag, " valid count"}, n_valid - b_v, ev);
    check({tag, " perror count"}, n_perr - b_p, ep);
    check({tag, " ferror count"}, n_ferr - b_f, ef);
    check({tag, " Rx_DATA"}, {24'd0, Rx_DATA}, {24'd0, ed});
  endtask

  // mode: 0 plain, 1 drop Rx_EN, 2 reset pulse, 3 change baud_select;
  // the action happens mid-way through frame bit at_idx (0 = start bit).
  task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop_bit,
                            input int bitclk, input int mode, input int at_idx);
    logic [10:0] bits;
    bits = {stop_bit, (^data) ^ par_flip, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      RxD = bits[i];
      if (i == 0) fall_cyc = cyc;
      if (mode != 0 && i == at_idx) begin
        repeat (bitclk / 2) @(negedge clk);
        case (mode)
          1: Rx_EN = 1'b0;
          2: begin
            reset = 1'b1;
            #1;
            check("reset mid-frame Rx_DATA", {24'd0, Rx_DATA}, 32'd0);
            check("reset mid-frame Rx_VALID", {31'd0, Rx_VALID}, 32'd0);
            check("reset mid-frame Rx_PERROR", {31'd0, Rx_PERROR}, 32'd0);
            check("reset mid-frame Rx_FERROR", {31'd0, Rx_FERROR}, 32'd0);
            repeat (3) @(negedge clk);
            reset = 1'b0;
          end
          3: baud_select = 3'b111;
          default: ;
        endcase
        repeat (bitclk - bitclk / 2) @(negedge clk);
        if (mode == 3) baud_select = 3'b011;
      end else begin
        repeat (bitclk) @(negedge clk);
      end
    end
    RxD = 1'b1;
  endtask

  initial begin
    // {data, par_flip, stop, exp_data, exp_v, exp_p, exp_f}
    vecs[0] = '{8'hAA, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hCC, 1'b0, 1'b1, 8'hCC, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h89, 1'b0, 1'b1, 8'h89, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hAA, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1};

    reset       = 1'b1;
    RxD         = 1'b1;
    Rx_EN       = 1'b1;
    baud_select = 3'b111;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("reset Rx_DATA", {24'd0, Rx_DATA}, 32'd0);
    check("reset Rx_VALID", {31'd0, Rx_VALID}, 32'd0);
    check("reset Rx_PERROR", {31'd0, Rx_PERROR}, 32'd0);
    check("reset Rx_FERROR", {31'd0, Rx_FERROR}, 32'd0);

    // Table-driven frames at 115200
    for (int i = 0; i < 6; i++) begin
      snap();
      send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop, Bit115k, 0, 0);
      repeat (Gap) @(negedge clk);
      frame_check($sformatf("vec%0d", i), int'(vecs[i].exp_v), int'(vecs[i].exp_p),
                  int'(vecs[i].exp_f), vecs[i].exp_data);
      if (i == 0) begin
        tests = tests + 1;
        if ((strobe_cyc - fall_cyc) < ExpLatency - 3 || (strobe_cyc - fall_cyc) > ExpLatency + 3)
        begin
          fails = fails + 1;
          $display("FAIL strobe latency: got %0d clk, expected %0d +/- 3",
                   strobe_cyc - fall_cyc, ExpLatency);
        end
      end
    end

    // 200 ns glitch -> false start, then a good 0x55
    snap();
    RxD = 1'b0;
    repeat (2) @(negedge clk);
    RxD = 1'b1;
    repeat (12 * Div115k) @(negedge clk);
    send_frame(8'h55, 1'b0, 1'b1, Bit115k, 0, 0);
    repeat (Gap) @(negedge clk);
    frame_check("glitch then 0x55", 1, 0, 0, 8'h55);

    // Rx_EN dropped during data bit 3 of 0xAA
    snap();
    send_frame(8'hAA, 1'b0, 1'b1, Bit115k, 1, 4);
    Rx_EN = 1'b1;
    repeat (Gap) @(negedge clk);
    frame_check("Rx_EN abort", 0, 0, 0, 8'h55);
    snap();
    send_frame(8'h55, 1'b0, 1'b1, Bit115k, 0, 0);
    repeat (Gap) @(negedge clk);
    frame_check("after abort 0x55", 1, 0, 0, 8'h55);

    // Line break: one 0x00 frame with framing error, no restart while low
    snap();
    RxD = 1'b0;
    repeat (24 * Bit115k) @(negedge clk);
    RxD = 1'b1;
    repeat (Gap) @(negedge clk);
    frame_check("line break", 0, 0, 1, 8'h00);

    // Back-to-back at 9600; baud_select wiggled mid-frame must be ignored
    baud_select = 3'b011;
    repeat (10) @(negedge clk);
    data_log.delete();
    snap();
    send_frame(8'h89, 1'b0, 1'b1, Bit9600, 3, 3);
    send_frame(8'hCC, 1'b0, 1'b1, Bit9600, 0, 0);
    repeat (Gap) @(negedge clk);
    frame_check("back-to-back", 2, 0, 0, 8'hCC);
    check("back-to-back strobe log size", data_log.size(), 32'd2);
    check("back-to-back first byte",
          (data_log.size() > 0) ? {24'd0, data_log[0]} : 32'hFFFF, 32'h89);
    check("back-to-back second byte",
          (data_log.size() > 1) ? {24'd0, data_log[1]} : 32'hFFFF, 32'hCC);

    // Reset mid-frame; the remaining bits of 0xF8 are all high so no new edge follows
    baud_select = 3'b111;
    repeat (Gap) @(negedge clk);
    snap();
    send_frame(8'hF8, 1'b0, 1'b1, Bit115k, 2, 5);
    repeat (Gap) @(negedge clk);
    frame_check("after reset", 0, 0, 0, 8'h00);

    snap();
    send_frame(8'h89, 1'b0, 1'b1, Bit115k, 0, 0);
    repeat (Gap) @(negedge clk);
    frame_check("post-reset 0x89", 1, 0, 0, 8'h89);

    check("strobes wider than one clk", wide_cnt, 32'd0);
    check("valid together with error", excl_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
